// File: rtl/program_loader_if.sv
// program_loader_if: byte stream handshake from a receiver into the program loader
interface program_loader_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   modport master (output rx_valid, rx_data, input rx_ready);
   modport slave (input rx_valid, rx_data, output rx_ready);
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a framed little-endian byte stream into instruction RAM words, then boots the core
module program_loader #(
   parameter int         ADDR_WIDTH       = 16,
   parameter int         TIMEOUT_CYCLES   = 1000000,
   parameter int         CPU_RESET_CYCLES = 4,
   parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   program_loader_if.slave       rx,
   output logic                  instruction_write,
   output logic [31:0]           instruction_in,
   output logic [ADDR_WIDTH-1:0] instruction_addr,
   output logic                  cpu_reset,
   output logic                  debug_enable,
   output logic                  load_done,
   output logic [1:0]            error_code
);
   localparam int MAX_WORDS = 2 ** (ADDR_WIDTH - 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = $clog2(CPU_RESET_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] RST_LAST = CW'(CPU_RESET_CYCLES - 1);
   localparam logic [3:0] IDLE    = 4'd0;
   localparam logic [3:0] LEN_LO  = 4'd1;
   localparam logic [3:0] LEN_HI  = 4'd2;
   localparam logic [3:0] DATA    = 4'd3;
   localparam logic [3:0] WRITE   = 4'd4;
   localparam logic [3:0] CHECK   = 4'd5;
   localparam logic [3:0] CPU_RST = 4'd6;
   localparam logic [3:0] RUN     = 4'd7;
   localparam logic [3:0] ERROR   = 4'd8;

   logic [3:0]            state;
   logic [7:0]            len_lo;
   logic [7:0]            chk;
   logic [15:0]           remaining;
   logic [1:0]            byte_idx;
   logic [TW-1:0]         tmo;
   logic [CW-1:0]         rst_cnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           word;
   logic                  accept;
   logic                  timed;
   logic                  overflow;
   logic [15:0]           len;

   // rx_ready is gated by reset so the receiver sees it low while reset is held
   assign rx.rx_ready = rst && state != WRITE && state != CPU_RST;
   assign accept = rx.rx_valid && rx.rx_ready;
   assign timed = state inside {LEN_LO, LEN_HI, DATA, CHECK};
   assign len = {rx.rx_data, len_lo};
   assign overflow = 32'(len) > 32'(MAX_WORDS);
   assign instruction_write = state == WRITE;
   assign instruction_in = word;
   assign instruction_addr = addr;
   assign cpu_reset = state == CPU_RST;
   assign debug_enable = state == RUN;
   assign load_done = state == RUN;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         len_lo     <= '0;
         chk        <= '0;
         remaining  <= '0;
         byte_idx   <= '0;
         tmo        <= '0;
         rst_cnt    <= '0;
         addr       <= '0;
         word       <= '0;
         error_code <= '0;
      end else begin
         tmo <= timed && !accept ? tmo + 1'b1 : '0;
         case (state)
            IDLE, RUN, ERROR: if (accept && rx.rx_data == SYNC_BYTE) begin
               state      <= LEN_LO;
               error_code <= '0;
               addr       <= '0;
               chk        <= '0;
               byte_idx   <= '0;
            end
            LEN_LO: if (accept) begin
               len_lo <= rx.rx_data;
               chk    <= chk ^ rx.rx_data;
               state  <= LEN_HI;
            end
            LEN_HI: if (accept) begin
               chk        <= chk ^ rx.rx_data;
               remaining  <= len;
               state      <= overflow ? ERROR : len == '0 ? CHECK : DATA;
               error_code <= overflow ? 2'b01 : 2'b00;
            end
            DATA: if (accept) begin
               word     <= {rx.rx_data, word[31:8]};
               chk      <= chk ^ rx.rx_data;
               byte_idx <= byte_idx + 1'b1;
               state    <= byte_idx == 2'd3 ? WRITE : DATA;
            end
            WRITE: begin
               addr      <= addr + ADDR_WIDTH'(4);
               remaining <= remaining - 1'b1;
               state     <= remaining == 16'd1 ? CHECK : DATA;
            end
            CHECK: if (accept) begin
               state      <= rx.rx_data == chk ? CPU_RST : ERROR;
               error_code <= rx.rx_data == chk ? 2'b00 : 2'b10;
               rst_cnt    <= '0;
            end
            CPU_RST: begin
               rst_cnt <= rst_cnt + 1'b1;
               state   <= rst_cnt == RST_LAST ? RUN : CPU_RST;
            end
            default: state <= IDLE;
         endcase
         if (timed && !accept && tmo == TMO_LAST) begin
            state      <= ERROR;
            error_code <= 2'b11;
         end
      end
   end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard-driven bench for the boot-time program loader
module tb_program_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instruction_write;
   logic [31:0] instruction_in;
   logic [15:0] instruction_addr;
   logic        cpu_reset;
   logic        debug_enable;
   logic        load_done;
   logic [1:0]  error_code;
   int tests = 0;
   int fails = 0;
   int wr_cnt = 0;
   int cpu_rst_cnt = 0;
   typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
   wr_t exp_q[$];
   wr_t got;

   program_loader_if rx_if();

   program_loader #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16), .CPU_RESET_CYCLES(4), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx_if),
      .instruction_write(instruction_write),
      .instruction_in(instruction_in),
      .instruction_addr(instruction_addr),
      .cpu_reset(cpu_reset),
      .debug_enable(debug_enable),
      .load_done(load_done),
      .error_code(error_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cpu_reset) cpu_rst_cnt++;
      if (instruction_write) begin
         wr_cnt++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", instruction_addr, instruction_in);
         end else begin
            got = exp_q.pop_front();
            if ({instruction_addr, instruction_in} !== got) begin
               fails++;
               $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h", instruction_addr, instruction_in, got.a, got.d);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_if.rx_valid = 1'b1;
      rx_if.rx_data = b;
      while (rx_if.rx_ready !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      if (n == 20) begin
         tests++;
         fails++;
         $display("FAIL rx_ready_wait: byte %h never accepted, expected rx_ready within 20 cycles", b);
      end
      tick(1);
      rx_if.rx_valid = 1'b0;
   endtask

   task automatic send_t1(input logic [7:0] chk);
      logic [7:0] f [12];
      f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h00, 8'h10, 8'h00, chk};
      exp_q.push_back('{16'h0000, 32'h00000013});
      exp_q.push_back('{16'h0004, 32'h001000B7});
      for (int i = 0; i < 12; i++) send_byte(f[i]);
   endtask

   task automatic test_reset;
      #1;
      tests++;
      if ({rx_if.rx_ready, instruction_write, instruction_in, instruction_addr, cpu_reset, debug_enable, load_done, error_code} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got rdy=%b wr=%b in=%h addr=%h cr=%b de=%b ld=%b ec=%b, expected all 0", rx_if.rx_ready, instruction_write, instruction_in, instruction_addr, cpu_reset, debug_enable, load_done, error_code);
      end
      @(negedge clk);
      rst = 1'b1;
      tick(1);
      tests++;
      if (rx_if.rx_ready !== 1'b1 || debug_enable !== 1'b0) begin
         fails++;
         $display("FAIL idle_after_reset: got rdy=%b de=%b, expected rdy=1 de=0", rx_if.rx_ready, debug_enable);
      end
   endtask

   task automatic test_load;
      cpu_rst_cnt = 0;
      send_t1(8'hB6);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL load_writes: got %0d writes missing, expected 0", exp_q.size());
      end
      tests++;
      if (cpu_reset !== 1'b1 || debug_enable !== 1'b0) begin
         fails++;
         $display("FAIL cpu_rst_start: got cr=%b de=%b, expected cr=1 de=0", cpu_reset, debug_enable);
      end
      tick(3);
      tests++;
      if (cpu_reset !== 1'b1) begin
         fails++;
         $display("FAIL cpu_rst_hold: got cr=%b, expected 1", cpu_reset);
      end
      tick(1);
      tests++;
      if ({cpu_reset, debug_enable, load_done, error_code} !== 5'b01100 || cpu_rst_cnt != 4 || instruction_addr !== 16'h0008) begin
         fails++;
         $display("FAIL run_state: got cr=%b de=%b ld=%b ec=%b pulse=%0d addr=%h, expected 0 1 1 00 4 0008", cpu_reset, debug_enable, load_done, error_code, cpu_rst_cnt, instruction_addr);
      end
   endtask

   task automatic test_reload;
      send_byte(8'hA5);
      tests++;
      if ({debug_enable, load_done} !== 2'b00 || instruction_addr !== 16'h0000) begin
         fails++;
         $display("FAIL resync: got de=%b ld=%b addr=%h, expected 0 0 0000", debug_enable, load_done, instruction_addr);
      end
      cpu_rst_cnt = 0;
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      tests++;
      if (cpu_reset !== 1'b1) begin
         fails++;
         $display("FAIL empty_frame_rst: got cr=%b, expected 1", cpu_reset);
      end
      tick(4);
      tests++;
      if ({debug_enable, load_done, error_code} !== 4'b1100 || cpu_rst_cnt != 4 || instruction_addr !== 16'h0000) begin
         fails++;
         $display("FAIL empty_frame_run: got de=%b ld=%b ec=%b pulse=%0d addr=%h, expected 1 1 00 4 0000", debug_enable, load_done, error_code, cpu_rst_cnt, instruction_addr);
      end
   endtask

   task automatic test_bad_chk;
      cpu_rst_cnt = 0;
      send_t1(8'h00);
      tests++;
      if (exp_q.size() != 0 || error_code !== 2'b10 || debug_enable !== 1'b0) begin
         fails++;
         $display("FAIL bad_chk: got pending=%0d ec=%b de=%b, expected 0 10 0", exp_q.size(), error_code, debug_enable);
      end
      tick(6);
      tests++;
      if (cpu_rst_cnt != 0 || error_code !== 2'b10 || load_done !== 1'b0) begin
         fails++;
         $display("FAIL bad_chk_hold: got pulse=%0d ec=%b ld=%b, expected 0 10 0", cpu_rst_cnt, error_code, load_done);
      end
   endtask

   task automatic test_overflow;
      int wr0 = wr_cnt;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h40);
      tests++;
      if (error_code !== 2'b00 || rx_if.rx_ready !== 1'b1) begin
         fails++;
         $display("FAIL max_words_ok: got ec=%b rdy=%b, expected 00 1", error_code, rx_if.rx_ready);
      end
      tick(16);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h40);
      tests++;
      if (error_code !== 2'b01) begin
         fails++;
         $display("FAIL overflow: got ec=%b, expected 01", error_code);
      end
      tick(3);
      tests++;
      if (wr_cnt != wr0 || error_code !== 2'b01) begin
         fails++;
         $display("FAIL overflow_hold: got writes=%0d ec=%b, expected %0d 01", wr_cnt, error_code, wr0);
      end
   endtask

   task automatic test_timeout;
      int wr0 = wr_cnt;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h13);
      send_byte(8'h00);
      tick(15);
      tests++;
      if (error_code !== 2'b00) begin
         fails++;
         $display("FAIL timeout_early: got ec=%b after 15 idle cycles, expected 00", error_code);
      end
      tick(1);
      tests++;
      if (error_code !== 2'b11 || wr_cnt != wr0) begin
         fails++;
         $display("FAIL timeout: got ec=%b writes=%0d after 16 idle cycles, expected 11 %0d", error_code, wr_cnt, wr0);
      end
   endtask

   task automatic test_async_reset;
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h13);
      send_byte(8'h00);
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if ({rx_if.rx_ready, instruction_write, instruction_in, instruction_addr, cpu_reset, debug_enable, load_done, error_code} !== '0) begin
         fails++;
         $display("FAIL async_reset: got rdy=%b wr=%b in=%h addr=%h cr=%b de=%b ld=%b ec=%b, expected all 0", rx_if.rx_ready, instruction_write, instruction_in, instruction_addr, cpu_reset, debug_enable, load_done, error_code);
      end
      @(negedge clk);
      rst = 1'b1;
      tick(1);
      cpu_rst_cnt = 0;
      send_t1(8'hB6);
      tick(5);
      tests++;
      if (exp_q.size() != 0 || load_done !== 1'b1 || debug_enable !== 1'b1 || cpu_rst_cnt != 4) begin
         fails++;
         $display("FAIL reload_after_reset: got pending=%0d ld=%b de=%b pulse=%0d, expected 0 1 1 4", exp_q.size(), load_done, debug_enable, cpu_rst_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data = 8'h00;
      test_reset;
      test_load;
      test_reload;
      test_bad_chk;
      test_overflow;
      test_timeout;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
